// File: rtl/gshare_predictor.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// gshare_predictor
//
// Global-history branch predictor. A table of 2-bit saturating counters is
// indexed by pc[INDEX_BITS+1:2] XOR the global history register. Predictions
// are combinational; training happens when the oldest in-flight branch
// resolves. The index used at prediction time is kept in a small in-order
// FIFO so that each resolution trains exactly the entry it predicted from.
//
// After reset the block sweeps the whole table to weakly-not-taken (INIT),
// then switches to RUN and raises o_ready.
//
// Handshake: there is no backpressure. A request is accepted in any RUN cycle
// where i_req_valid=1, and the prediction is valid in that same cycle.
// A resolution is accepted in any RUN cycle where i_fb_valid=1 and always
// refers to the oldest outstanding request. Both are ignored during INIT.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   i_req_valid/i_req_pc  branch decoded this cycle and its PC
//   o_req_prediction      1 = taken (combinational)
//   i_fb_valid            oldest in-flight branch resolved this cycle
//   i_fb_prediction       prediction originally issued for that branch
//   i_fb_outcome          actual direction, 1 = taken
//   i_flush               drop all in-flight FIFO entries
//   o_ready               table initialised, predictor active
//   o_fifo_overflow       sticky: a push was dropped on a full FIFO
//   o_pred_count          accepted predictions (wraps)
//   o_mispredict_count    resolutions with prediction != outcome (wraps)
//
// Constraints: 2 <= GHR_BITS <= INDEX_BITS, FIFO_DEPTH a power of 2, >= 2.
// -----------------------------------------------------------------------------
module gshare_predictor #(
    parameter int INDEX_BITS = 8,
    parameter int GHR_BITS   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    input  logic [31:0] i_req_pc,
    output logic        o_req_prediction,
    input  logic        i_fb_valid,
    input  logic        i_fb_prediction,
    input  logic        i_fb_outcome,
    input  logic        i_flush,
    output logic        o_ready,
    output logic        o_fifo_overflow,
    output logic [31:0] o_pred_count,
    output logic [31:0] o_mispredict_count
);

    localparam int TABLE_SIZE = 1 << INDEX_BITS;
    localparam int PTR_BITS   = $clog2(FIFO_DEPTH);
    localparam int CNT_BITS   = PTR_BITS + 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // ---------------------------------------------------------------- state
    state_t                r_state;
    logic                  r_ready;
    logic [INDEX_BITS-1:0] r_init_ptr;
    logic [GHR_BITS-1:0]   r_ghr;
    logic [1:0]            r_table [TABLE_SIZE];
    logic [INDEX_BITS-1:0] r_fifo  [FIFO_DEPTH];
    logic [PTR_BITS-1:0]   r_rd_ptr;
    logic [PTR_BITS-1:0]   r_wr_ptr;
    logic [CNT_BITS-1:0]   r_count;
    logic                  r_overflow;
    logic [31:0]           r_pred_count;
    logic [31:0]           r_misp_count;

    // ---------------------------------------------------------------- wires
    logic                  w_run;
    logic [INDEX_BITS-1:0] w_ghr_ext;
    logic [INDEX_BITS-1:0] w_req_idx;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_req;
    logic                  w_flush;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [INDEX_BITS-1:0] w_head_idx;
    logic [1:0]            w_head_ctr;
    logic [1:0]            w_trained_ctr;
    logic                  w_tbl_we;
    logic [INDEX_BITS-1:0] w_tbl_addr;
    logic [1:0]            w_tbl_data;
    logic                  w_unused_pc;

    // PC bits outside the index field do not participate in the hash.
    assign w_unused_pc = &{1'b0, i_req_pc[31:INDEX_BITS+2], i_req_pc[1:0]};

    assign w_run = (r_state == ST_RUN);

    // History is narrower than (or equal to) the index; zero-extend it.
    always_comb begin
        w_ghr_ext                 = '0;
        w_ghr_ext[GHR_BITS-1:0]   = r_ghr;
    end

    assign w_req_idx = i_req_pc[INDEX_BITS+1:2] ^ w_ghr_ext;

    // Reads see the table as it was before this cycle's edge, so a request
    // that hits the entry being trained gets the old counter value.
    assign o_req_prediction = w_run & r_table[w_req_idx][1];

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_BITS'(FIFO_DEPTH));
    assign w_req   = w_run & i_req_valid;
    assign w_flush = w_run & i_flush;
    assign w_pop   = w_run & i_fb_valid & ~w_empty;

    // A full FIFO still accepts a push if a slot frees up this cycle, either
    // by a pop or by a flush (which clears before the push lands).
    assign w_push = w_req & (~w_full | w_pop | w_flush);
    assign w_drop = w_req & w_full & ~w_pop & ~w_flush;

    assign w_head_idx = r_fifo[r_rd_ptr];
    assign w_head_ctr = r_table[w_head_idx];

    always_comb begin
        w_trained_ctr = w_head_ctr;
        if (i_fb_outcome) begin
            if (w_head_ctr != 2'b11) begin
                w_trained_ctr = w_head_ctr + 2'd1;
            end
        end else begin
            if (w_head_ctr != 2'b00) begin
                w_trained_ctr = w_head_ctr - 2'd1;
            end
        end
    end

    // One write port: the init sweep owns it in INIT, training owns it in RUN.
    assign w_tbl_we   = ~rst & (~w_run | w_pop);
    assign w_tbl_addr = w_run ? w_head_idx : r_init_ptr;
    assign w_tbl_data = w_run ? w_trained_ctr : 2'b01;

    always_ff @(posedge clk) begin
        if (w_tbl_we) begin
            r_table[w_tbl_addr] <= w_tbl_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_req_idx;
        end
    end

    // ------------------------------------------------------- control / FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_INIT;
            r_ready      <= 1'b0;
            r_init_ptr   <= '0;
            r_ghr        <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_pred_count <= '0;
            r_misp_count <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_init_ptr <= r_init_ptr + 1'b1;
                    if (r_init_ptr == '1) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_req) begin
                        r_pred_count <= r_pred_count + 32'd1;
                    end
                    if (w_drop) begin
                        r_overflow <= 1'b1;
                    end
                    if (i_fb_valid) begin
                        r_ghr <= {r_ghr[GHR_BITS-2:0], i_fb_outcome};
                        if (i_fb_prediction != i_fb_outcome) begin
                            r_misp_count <= r_misp_count + 32'd1;
                        end
                    end

                    if (w_push) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    end

                    // Flush discards everything still queued (the head has
                    // already been trained this cycle if w_pop), then the
                    // new request, if any, becomes the only entry.
                    if (w_flush) begin
                        r_rd_ptr <= r_wr_ptr;
                        r_count  <= w_push ? CNT_BITS'(1) : '0;
                    end else begin
                        if (w_pop) begin
                            r_rd_ptr <= r_rd_ptr + 1'b1;
                        end
                        case ({w_push, w_pop})
                            2'b10:   r_count <= r_count + 1'b1;
                            2'b01:   r_count <= r_count - 1'b1;
                            default: r_count <= r_count;
                        endcase
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign o_ready            = r_ready;
    assign o_fifo_overflow    = r_overflow;
    assign o_pred_count       = r_pred_count;
    assign o_mispredict_count = r_misp_count;

endmodule
